// File: rtl/watchdog_pkg.sv
// Shared state encoding and default constants for the watchdog reset-request block.
package watchdog_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    FIRE    = 2'd2,
    HOLDOFF = 2'd3
  } wdt_state_e;

  localparam int TIMEOUT_W_DEF = 16;
  localparam int PULSE_MIN_DEF = 4;
  localparam int ACK_LIMIT_DEF = 32;

endpackage

// File: rtl/wdt_reload_counter.sv
// Loadable down counter that saturates at zero; load has priority over decrement.
module wdt_reload_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/watchdog_reset_req.sv
// Watchdog countdown plus reset request/acknowledge handshake; reset_req is
// driven straight from a flop so the downstream async reset never sees a glitch.
module watchdog_reset_req
  import watchdog_pkg::*;
#(
  parameter int TIMEOUT_W = TIMEOUT_W_DEF,
  parameter int PULSE_MIN = PULSE_MIN_DEF,
  parameter int ACK_LIMIT = ACK_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 kick,
  input  logic                 sw_req,
  input  logic                 clear_flags,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 reset_ack,
  output logic                 reset_req,
  output logic                 expired,
  output logic                 ack_err,
  output logic [1:0]           state
);

  localparam int P_W = (ACK_LIMIT > 1) ? $clog2(ACK_LIMIT) : 1;

  wdt_state_e           state_q;
  logic [P_W-1:0]       p_cnt;
  logic                 ack_seen;
  logic [TIMEOUT_W-1:0] count;
  logic                 cnt_zero;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 armed_run;
  logic                 expiry_fire;
  logic                 ack_now;
  logic                 pulse_done;
  logic                 ack_timeout;

  // ARMED priority: sw_req, then enable low, then kick, then expiry
  assign armed_run   = (state_q == ARMED) && !sw_req && enable;
  assign cnt_load    = ((state_q == IDLE) && !sw_req && enable) || (armed_run && kick);
  assign cnt_dec     = armed_run && !kick;
  assign expiry_fire = armed_run && !kick && cnt_zero;

  assign ack_now     = ack_seen | reset_ack;
  assign pulse_done  = (state_q == FIRE) && ack_now && (p_cnt >= P_W'(PULSE_MIN - 1));
  assign ack_timeout = (state_q == FIRE) && !pulse_done && (p_cnt == P_W'(ACK_LIMIT - 1));

  assign state = state_q;

  wdt_reload_counter #(
    .W(TIMEOUT_W)
  ) u_countdown (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (timeout),
    .dec      (cnt_dec),
    .count    (count),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      p_cnt     <= '0;
      ack_seen  <= 1'b0;
      reset_req <= 1'b0;
      expired   <= 1'b0;
      ack_err   <= 1'b0;
    end else begin
      // A flag set in the same cycle as clear_flags wins over the clear
      expired <= expiry_fire | (expired & ~clear_flags);
      ack_err <= ack_timeout | (ack_err & ~clear_flags);

      case (state_q)
        IDLE: begin
          if (sw_req) begin
            state_q   <= FIRE;
            reset_req <= 1'b1;
            p_cnt     <= '0;
            ack_seen  <= 1'b0;
          end else if (enable) begin
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (sw_req || expiry_fire) begin
            state_q   <= FIRE;
            reset_req <= 1'b1;
            p_cnt     <= '0;
            ack_seen  <= 1'b0;
          end else if (!enable) begin
            state_q <= IDLE;
          end
        end
        FIRE: begin
          if (pulse_done || ack_timeout) begin
            state_q   <= HOLDOFF;
            reset_req <= 1'b0;
          end else begin
            p_cnt    <= p_cnt + P_W'(1);
            ack_seen <= ack_now;
          end
        end
        HOLDOFF: begin
          if (!reset_ack) state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          reset_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_watchdog_reset_req.sv
// Directed bench for watchdog_reset_req: vector table plus multi-cycle sequences.
module tb_watchdog_reset_req;
  import watchdog_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        kick = 1'b0;
  logic        sw_req = 1'b0;
  logic        clear_flags = 1'b0;
  logic [15:0] timeout = '0;
  logic        reset_ack = 1'b0;
  logic        reset_req;
  logic        expired;
  logic        ack_err;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  logic h1 = 1'b0;
  logic h2 = 1'b0;

  typedef struct {
    logic        en, kk, sw, clr;
    logic [15:0] to;
    logic        ack;
    logic        req, exp, err;
    logic [1:0]  st;
  } vec_t;

  vec_t vt[$];

  always #5 clk = ~clk;

  watchdog_reset_req #(
    .TIMEOUT_W(16),
    .PULSE_MIN(4),
    .ACK_LIMIT(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .kick        (kick),
    .sw_req      (sw_req),
    .clear_flags (clear_flags),
    .timeout     (timeout),
    .reset_ack   (reset_ack),
    .reset_req   (reset_req),
    .expired     (expired),
    .ack_err     (ack_err),
    .state       (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // reset_ack follows reset_req two cycles later
  task automatic step_dly();
    tick();
    reset_ack = h2;
    h2 = h1;
    h1 = reset_req;
  endtask

  task automatic add(input logic en, kk, sw, clr, input logic [15:0] to, input logic ack,
                     input logic req, exp, err, input logic [1:0] st);
    vec_t v;
    v.en = en; v.kk = kk; v.sw = sw; v.clr = clr; v.to = to; v.ack = ack;
    v.req = req; v.exp = exp; v.err = err; v.st = st;
    vt.push_back(v);
  endtask

  task automatic finish_fire(input string name);
    enable = 1'b0;
    reset_ack = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (state == 2'd3) break;
    end
    reset_ack = 1'b0;
    tick();
    chk(name, state, 2'd0);
  endtask

  initial begin
    int n;
    int hc;
    int bad;

    #3;
    chk("rst_req", reset_req, 0);
    chk("rst_state", state, 0);
    chk("rst_expired", expired, 0);
    chk("rst_ack_err", ack_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // timeout=0, set-over-clear, clear
    add(1,0,0,0, 0,0, 0,0,0,1);
    add(1,0,0,0, 0,0, 1,1,0,2);
    add(1,0,0,0, 0,1, 1,1,0,2);
    add(0,0,0,0, 0,0, 1,1,0,2);
    add(0,0,0,0, 0,0, 1,1,0,2);
    add(0,0,0,0, 0,0, 0,1,0,3);
    add(0,0,0,0, 0,0, 0,1,0,0);
    add(1,0,0,0, 0,0, 0,1,0,1);
    add(1,0,0,1, 0,0, 1,1,0,2);
    add(0,0,0,0, 0,1, 1,1,0,2);
    add(0,0,0,0, 0,1, 1,1,0,2);
    add(0,0,0,0, 0,1, 1,1,0,2);
    add(0,0,0,0, 0,1, 0,1,0,3);
    add(0,0,0,0, 0,0, 0,1,0,0);
    add(0,0,0,1, 0,0, 0,0,0,0);
    // kick at count==0 reloads, enable low beats expiry
    add(1,0,0,0, 2,0, 0,0,0,1);
    add(1,0,0,0, 2,0, 0,0,0,1);
    add(1,0,0,0, 2,0, 0,0,0,1);
    add(1,1,0,0, 2,0, 0,0,0,1);
    add(1,0,0,0, 2,0, 0,0,0,1);
    add(1,0,0,0, 2,0, 0,0,0,1);
    add(0,0,0,0, 2,0, 0,0,0,0);
    // sw_req with coincident kick, ignored strobes in FIRE/HOLDOFF
    add(1,0,0,0, 5,0, 0,0,0,1);
    add(1,1,1,0, 5,0, 1,0,0,2);
    add(1,0,0,0, 5,1, 1,0,0,2);
    add(1,1,1,0, 5,0, 1,0,0,2);
    add(0,0,0,0, 5,0, 1,0,0,2);
    add(0,0,0,0, 5,0, 0,0,0,3);
    add(0,0,1,0, 5,1, 0,0,0,3);
    add(0,0,0,0, 5,0, 0,0,0,0);
    // sw_req from IDLE
    add(0,0,1,0, 5,0, 1,0,0,2);

    foreach (vt[i]) begin
      enable = vt[i].en; kick = vt[i].kk; sw_req = vt[i].sw;
      clear_flags = vt[i].clr; timeout = vt[i].to; reset_ack = vt[i].ack;
      tick();
      chk($sformatf("v%0d_req", i), reset_req, vt[i].req);
      chk($sformatf("v%0d_expired", i), expired, vt[i].exp);
      chk($sformatf("v%0d_ack_err", i), ack_err, vt[i].err);
      chk($sformatf("v%0d_state", i), state, vt[i].st);
    end
    enable = 0; kick = 0; sw_req = 0; clear_flags = 0; reset_ack = 0;

    // no ack: pulse capped at ACK_LIMIT cycles
    hc = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!reset_req) break;
      hc++;
    end
    chk("noack_high_cycles", hc, 32);
    chk("noack_ack_err", ack_err, 1);
    chk("noack_expired", expired, 0);
    chk("noack_holdoff", state, 3);
    tick();
    chk("noack_idle", state, 0);
    enable = 1; timeout = 1;
    tick(); tick(); tick();
    chk("t1_fire", state, 2);
    chk("t1_expired", expired, 1);
    finish_fire("t1_done");
    chk("both_exp", expired, 1);
    chk("both_err", ack_err, 1);
    clear_flags = 1;
    tick();
    clear_flags = 0;
    chk("clear_exp", expired, 0);
    chk("clear_err", ack_err, 0);

    // timeout=10, ack = req delayed by two cycles
    enable = 1; timeout = 10; h1 = 0; h2 = 0; reset_ack = 0;
    tick();
    chk("d_armed", state, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step_dly();
      n++;
      if (reset_req) break;
    end
    chk("d_rise_latency", n, 11);
    enable = 0;
    hc = 1;
    for (int i = 0; i < 40; i++) begin
      step_dly();
      if (!reset_req) break;
      hc++;
    end
    chk("d_high_cycles", hc, 4);
    chk("d_expired", expired, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step_dly();
      n++;
      if (state == 2'd0) break;
    end
    chk("d_idle_delay", n, 3);
    reset_ack = 0;
    clear_flags = 1;
    tick();
    clear_flags = 0;

    // periodic kicks keep it quiet, then request follows last kick by T+1
    enable = 1; timeout = 10;
    tick();
    bad = 0;
    for (int c = 1; c <= 104; c++) begin
      kick = (c % 8 == 0);
      tick();
      if (reset_req) bad++;
    end
    kick = 0;
    chk("kick_no_req", bad, 0);
    chk("kick_armed", state, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (reset_req) break;
    end
    chk("kick_rise_latency", n, 11);
    finish_fire("kick_done");

    // async reset in the second FIRE cycle
    enable = 1; timeout = 0;
    tick(); tick(); tick();
    enable = 0;
    chk("ar_pre_req", reset_req, 1);
    chk("ar_pre_exp", expired, 1);
    #2;
    rst_n = 0;
    #1;
    chk("ar_req", reset_req, 0);
    chk("ar_state", state, 0);
    chk("ar_expired", expired, 0);
    chk("ar_ack_err", ack_err, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("ar_after", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/watchdog_reset_req.md
# watchdog_reset_req

Watchdog and reset-request initiator: counts down a programmable timeout and, when firmware fails to kick it or requests a reset explicitly, drives a clean registered reset request pulse. `reset_req` connects to the async reset input of the reset synchronizer. The synchronized reset output returns as `reset_ack`, which closes the request/acknowledge loop. `rst_n` must come from the power-on reset domain, never from the synchronizer this block drives.

## Interface
- `TIMEOUT_W`, 16: width of timeout value and countdown counter
- `PULSE_MIN`, 4: minimum `reset_req` high time in cycles, ≥1
- `ACK_LIMIT`, 32: maximum cycles in FIRE waiting for `reset_ack`, must be > `PULSE_MIN`
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `enable` in 1: level; arms the watchdog
- `kick` in 1: one-cycle strobe; reloads the countdown
- `sw_req` in 1: one-cycle strobe; immediate reset request
- `clear_flags` in 1: strobe; clears the sticky flags
- `timeout` in `TIMEOUT_W`: reload value, sampled on load
- `reset_ack` in 1: synchronized reset output fed back
- `reset_req` out 1: registered reset request, glitch-free
- `expired` out 1: sticky; set when the countdown caused FIRE
- `ack_err` out 1: sticky; set when FIRE ended by `ACK_LIMIT` without ack
- `state` out 2: current FSM state, for debug

## Operation
- Reset values: state=IDLE, count=0, pulse count=0, `reset_req`=0, `expired`=0, `ack_err`=0.
- Reset is asynchronous. `reset_req` drops immediately on `rst_n` low, even mid-FIRE.
- IDLE (0): `reset_req`=0.
  - `enable`=1 → ARMED with count←`timeout`.
  - `sw_req` in IDLE → FIRE.
- ARMED (1):
  - Each cycle: count decrements, unless `kick`=1, which reloads count←`timeout`.
  - `enable`=0 → IDLE.
  - count==0 and no kick → FIRE, and `expired`←1.
  - `sw_req` → FIRE; `expired` is unchanged.
- FIRE (2): `reset_req`=1, pulse count p increments from 0.
  - `reset_ack`=1 sets an internal `ack_seen`.
  - Exit to HOLDOFF when p ≥ `PULSE_MIN`−1 and `ack_seen` (current cycle included).
  - Otherwise exit to HOLDOFF when p == `ACK_LIMIT`−1, and `ack_err`←1.
  - `enable`, `kick` and `sw_req` are ignored.
- HOLDOFF (3): `reset_req`=0. Waits for `reset_ack`==0 sampled, then → IDLE.
  - `kick` and `sw_req` are ignored.
- Priority in ARMED: `sw_req` > `enable`=0 > `kick` > count expiry.
- `kick` at count==0 reloads and does not fire.
- `timeout`=0: the first decrement is skipped, so FIRE occurs on the cycle after entry. Count never wraps below 0.
- `clear_flags` clears `expired`/`ack_err`. A set in the same cycle takes priority over the clear.

## Timing
- `enable` seen high at edge E0 → ARMED at E0 with count=T.
- With no kicks, count reaches 0 at E(T). At E(T+1) the state is FIRE and `reset_req`=1.
- Latency from arming to request is T+1 cycles. A kick at edge Ek restarts this, giving `reset_req` at Ek+T+1.
- `sw_req` at edge E → `reset_req`=1 after E (1 cycle latency).
- `reset_req` high time: max(`PULSE_MIN`, first ack cycle+1) cycles, capped at `ACK_LIMIT`.
- HOLDOFF is at least 1 cycle. Earliest re-arm is 1 cycle after IDLE is reached.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `watchdog_pkg` holds:
  - the state enum: IDLE=2'd0, ARMED=2'd1, FIRE=2'd2, HOLDOFF=2'd3
  - default widths/constants `PULSE_MIN_DEF`, `ACK_LIMIT_DEF`
- Sub-module `wdt_reload_counter` is a parameterized down counter with load, decrement enable and a `zero` flag. Instantiate it once for the countdown. The pulse count p is a local `$clog2(ACK_LIMIT)`-bit counter.

## Test plan
- `timeout`=10, `enable`=1, no kicks, `reset_ack` = `reset_req` delayed 2 cycles → `reset_req` rises 11 cycles after ARMED, high 4 cycles, `expired`=1; IDLE follows once `reset_ack` falls.
- `timeout`=10, kick every 8 cycles for 100 cycles → `reset_req` never asserts. Stop kicking at cycle 104 → `reset_req` rises 11 cycles after the last kick.
- `sw_req` in ARMED with count=5 → `reset_req`=1 next cycle, `expired`=0. A `kick` in the same cycle does not suppress it.
- `reset_ack` tied 0 → `reset_req` high exactly 32 cycles, `ack_err`=1. `clear_flags` then clears both flags.
- `rst_n` low during FIRE (cycle 2) → `reset_req`=0 asynchronously, state=IDLE, flags=0.
- `timeout`=0 → FIRE one cycle after ARMED. `kick` coincident with count==0 → reload, no FIRE.
